// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Holds the FSM state encoding and the width of the optional BUSY timeout counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Width of the BUSY-state watchdog counter (MEM_ARB_TIMEOUT_EN builds only)
    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Returns the first active requester strictly after ptr, wrapping modulo NUM_REQ.
// The pointer register itself lives in the parent so this block stays stateless.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0]   win_idx,
    output logic               win_valid
);

    logic [PTR_W-1:0] idx_next;
    logic [PTR_W-1:0] cand;
    logic             found_next;

    // Scan from farthest to nearest; the last hit is the nearest active requester after ptr
    always_comb begin
        idx_next   = '0;
        cand       = '0;
        found_next = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                idx_next   = cand;
                found_next = 1'b1;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign win_onehot[gi] = found_next && (idx_next == PTR_W'(gi));
    end

    assign win_idx   = idx_next;
    assign win_valid = found_next;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ level-request agents.
// One transaction in flight; memory-side outputs are registered. A RESP turnaround
// cycle follows every completion so a requester can drop its level request.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          mem_clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_REQ-1:0]            req_sel_i,
    input  logic [NUM_REQ-1:0]            req_wen_i,
    input  logic [NUM_REQ-1:0]            req_ren_i,
    output logic [DATA_WIDTH-1:0]         req_rdata_o,
    output logic                          req_err_o,
    output logic [NUM_REQ-1:0]            req_ack_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic                          mem_sel_o,
    output logic                          mem_wen_o,
    output logic                          mem_ren_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    input  logic                          mem_err_i,
    input  logic                          mem_ack_i
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Reject configurations the pointer/counter widths cannot represent
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_param_check
        $error("mem_bus_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
    end

    arb_state_t            state_reg;
    logic [PTR_W-1:0]      ptr_reg;
    logic [NUM_REQ-1:0]    active;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_valid;
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    assign active = req_wen_i | req_ren_i;

    // Unpack the per-requester buses so the winner can be selected by index
    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req        (active),
        .ptr        (ptr_reg),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_CNT_W-1:0] tmo_cnt_reg;
`endif

    // Arbitration FSM plus all registered memory-side and requester-side outputs
    always_ff @(posedge mem_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= PTR_W'(NUM_REQ - 1);
            grant_o     <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_sel_o   <= 1'b0;
            mem_wen_o   <= 1'b0;
            mem_ren_o   <= 1'b0;
            req_ack_o   <= '0;
            req_rdata_o <= '0;
            req_err_o   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
        end else begin
            req_ack_o <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        mem_addr_o  <= addr_arr[win_idx];
                        mem_wdata_o <= wdata_arr[win_idx];
                        mem_sel_o   <= req_sel_i[win_idx];
                        // Write wins when a requester raises both strobes
                        mem_wen_o   <= req_wen_i[win_idx];
                        mem_ren_o   <= ~req_wen_i[win_idx];
                        grant_o     <= win_onehot;
                        ptr_reg     <= win_idx;
                        state_reg   <= ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt_reg <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (mem_ack_i) begin
                        req_rdata_o <= mem_rdata_i;
                        req_err_o   <= mem_err_i;
                        req_ack_o   <= grant_o;
                        grant_o     <= '0;
                        mem_wen_o   <= 1'b0;
                        mem_ren_o   <= 1'b0;
                        state_reg   <= ST_RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_cnt_reg == TMO_LAST) begin
                        req_rdata_o <= '0;
                        req_err_o   <= 1'b1;
                        req_ack_o   <= grant_o;
                        grant_o     <= '0;
                        mem_wen_o   <= 1'b0;
                        mem_ren_o   <= 1'b0;
                        state_reg   <= ST_RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_CNT_W'(1);
                    end
`endif
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (NUM_REQ=2). A transaction-level model
// predicts every output each cycle; directed tests pin key results with literals.
// The timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_sel, req_wen, req_ren;
    logic [DW-1:0]     req_rdata_o;
    logic              req_err_o;
    logic [NR-1:0]     req_ack_o, grant_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic              mem_sel_o, mem_wen_o, mem_ren_o;
    logic [DW-1:0]     mem_rdata_q;
    logic              mem_err_q, mem_ack_q, spur_ack, mem_ack_w;

    assign mem_ack_w = mem_ack_q | spur_ack;

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .mem_clk_i(clk), .rst_n_i(rst_n),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
        .req_wen_i(req_wen), .req_ren_i(req_ren),
        .req_rdata_o(req_rdata_o), .req_err_o(req_err_o), .req_ack_o(req_ack_o),
        .grant_o(grant_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
        .mem_wen_o(mem_wen_o), .mem_ren_o(mem_ren_o),
        .mem_rdata_i(mem_rdata_q), .mem_err_i(mem_err_q), .mem_ack_i(mem_ack_w)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    int          mem_lat = 0;
    bit          mem_hang = 0;
    int          mem_cnt = 0;
    logic [DW-1:0] mem_rdata_nx = '0;
    logic          mem_err_nx = 1'b0;

    initial begin : mem_model
        mem_ack_q = 1'b0; mem_rdata_q = '0; mem_err_q = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mem_ack_q = 1'b0; mem_cnt = 0;
            end else if (mem_ack_q) begin
                mem_ack_q = 1'b0; mem_cnt = 0;
            end else if (mem_wen_o | mem_ren_o) begin
                if (!mem_hang && mem_cnt >= mem_lat) begin
                    mem_ack_q = 1'b1; mem_rdata_q = mem_rdata_nx; mem_err_q = mem_err_nx;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    int            m_owner, m_last, m_cool, m_ack, m_edge, m_gedge;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_sel, m_write, m_err;

    task automatic m_reset();
        m_owner = -1; m_last = NR - 1; m_cool = 0; m_ack = -1;
        m_edge = 0; m_gedge = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_sel = 0; m_write = 0; m_err = 0;
    endtask

    task automatic m_step();
        int  c;
        bit  found;
        m_edge++;
        m_ack = -1;
        if (m_owner >= 0) begin
            if (mem_ack_w) begin
                m_rdata = mem_rdata_q; m_err = mem_err_q; m_ack = m_owner;
                m_owner = -1; m_cool = 1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (m_edge - m_gedge == TO) begin
                m_rdata = '0; m_err = 1'b1; m_ack = m_owner;
                m_owner = -1; m_cool = 1;
            end
`endif
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (!found && (req_wen[c] || req_ren[c])) begin
                    found = 1; m_owner = c; m_last = c; m_gedge = m_edge;
                    m_addr = req_addr[c*AW +: AW]; m_wdata = req_wdata[c*DW +: DW];
                    m_sel = req_sel[c]; m_write = req_wen[c];
                end
            end
        end
    endtask

    initial begin : model_proc
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin : cyc_proc
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- compare + transaction log ----------------
    logic [AW-1:0] g_addr_q[$];
    logic [DW-1:0] g_wd_q[$];
    logic [NR-1:0] g_own_q[$];
    logic          g_wen_q[$], g_ren_q[$];
    int            g_cyc_q[$];
    logic [NR-1:0] ack_q[$];
    logic [DW-1:0] rd_q[$];
    logic          er_q[$];
    int            ack_cyc_q[$];

    initial begin : compare
        logic [NR-1:0] prev_grant, eg, ea;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            eg = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
            ea = (m_ack >= 0) ? (NR'(1) << m_ack) : '0;
            chk("grant", 64'(grant_o), 64'(eg));
            chk("mem_wen", 64'(mem_wen_o), 64'(m_owner >= 0 && m_write));
            chk("mem_ren", 64'(mem_ren_o), 64'(m_owner >= 0 && !m_write));
            if (m_owner >= 0) begin
                chk("mem_addr", 64'(mem_addr_o), 64'(m_addr));
                chk("mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
                chk("mem_sel", 64'(mem_sel_o), 64'(m_sel));
            end
            chk("req_ack", 64'(req_ack_o), 64'(ea));
            chk("req_rdata", 64'(req_rdata_o), 64'(m_rdata));
            chk("req_err", 64'(req_err_o), 64'(m_err));
            if (grant_o != '0 && prev_grant == '0) begin
                g_addr_q.push_back(mem_addr_o); g_wd_q.push_back(mem_wdata_o);
                g_own_q.push_back(grant_o); g_wen_q.push_back(mem_wen_o);
                g_ren_q.push_back(mem_ren_o); g_cyc_q.push_back(cyc);
            end
            if (req_ack_o != '0) begin
                ack_q.push_back(req_ack_o); rd_q.push_back(req_rdata_o);
                er_q.push_back(req_err_o); ack_cyc_q.push_back(cyc);
                $display("txn %0d: ack=%b rdata=%h err=%b cycle=%0d",
                         ack_q.size(), req_ack_o, req_rdata_o, req_err_o, cyc);
            end
            prev_grant = grant_o;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_wen = '0; req_ren = '0; req_sel = '0;
        mem_hang = 0; spur_ack = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_acks(input int target, input int max);
        int c;
        c = 0;
        while (ack_q.size() < target && c < max) begin
            tick(1); c++;
        end
        chk("ack_arrival", 64'(ack_q.size() >= target), 64'(1));
    endtask

    task automatic wait_grant(input int max);
        int c;
        c = 0;
        while (grant_o == '0 && c < max) begin
            tick(1); c++;
        end
        chk("grant_arrival", 64'(grant_o != '0), 64'(1));
    endtask

    task automatic set_req(input int idx, input bit wr, input bit rd,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[idx*AW +: AW] = a; req_wdata[idx*DW +: DW] = d;
        req_sel[idx] = 1'b1; req_wen[idx] = wr; req_ren[idx] = rd;
    endtask

    task automatic drop_req(input int idx);
        req_sel[idx] = 1'b0; req_wen[idx] = 1'b0; req_ren[idx] = 1'b0;
    endtask

    task automatic do_txn(input int idx, input bit wr, input bit rd,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int lat, input logic [DW-1:0] rdv, input logic e);
        int n0;
        n0 = ack_q.size();
        mem_lat = lat; mem_rdata_nx = rdv; mem_err_nx = e;
        set_req(idx, wr, rd, a, d);
        wait_acks(n0 + 1, 40);
        drop_req(idx);
        tick(1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin : stim
        int a0, g0;
        rst_n = 1'b1; req_addr = '0; req_wdata = '0;
        req_sel = '0; req_wen = '0; req_ren = '0; spur_ack = 1'b0;
        #1;
        do_reset();

        // Reset state
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_addr", 64'(mem_addr_o), 64'(0));
        chk("rst_rdata", 64'(req_rdata_o), 64'(0));
        chk("rst_strobes", 64'({mem_wen_o, mem_ren_o}), 64'(0));

        // Single read, memory acks after a 3-cycle wait
        a0 = ack_q.size(); g0 = g_addr_q.size();
        do_txn(0, 0, 1, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        chk("t1_addr", 64'(g_addr_q[g0]), 64'(32'h100));
        chk("t1_ren", 64'(g_ren_q[g0]), 64'(1));
        chk("t1_ack", 64'(ack_q[a0]), 64'(2'b01));
        chk("t1_rdata", 64'(rd_q[a0]), 64'(32'hDEADBEEF));
        chk("t1_err", 64'(er_q[a0]), 64'(0));
        chk("t1_latency", 64'(ack_cyc_q[a0] - g_cyc_q[g0]), 64'(4));

        // Spurious mem ack while idle is ignored
        a0 = ack_q.size();
        spur_ack = 1'b1; tick(1); spur_ack = 1'b0; tick(2);
        chk("spur_no_ack", 64'(ack_q.size()), 64'(a0));
        chk("spur_rdata_hold", 64'(req_rdata_o), 64'(32'hDEADBEEF));

        // Contention: both write continuously, zero-wait memory
        do_reset();
        a0 = ack_q.size(); g0 = g_addr_q.size();
        mem_lat = 0; mem_rdata_nx = 32'h0; mem_err_nx = 1'b0;
        set_req(0, 1, 0, 32'h10, 32'hA);
        set_req(1, 1, 0, 32'h20, 32'hB);
        wait_acks(a0 + 4, 40);
        drop_req(0); drop_req(1);
        tick(3);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", 64'(g_addr_q[g0+i]), 64'((i % 2 == 0) ? 32'h10 : 32'h20));
            chk("t2_ack", 64'(ack_q[a0+i]), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
            if (i > 0) chk("t2_spacing", 64'(g_cyc_q[g0+i] - g_cyc_q[g0+i-1]), 64'(3));
        end

        // wen and ren both high on req1: write wins
        do_reset();
        g0 = g_addr_q.size();
        do_txn(1, 1, 1, 32'h30, 32'h55AA, 2, 32'h77, 1'b0);
        chk("t3_owner", 64'(g_own_q[g0]), 64'(2'b10));
        chk("t3_wen", 64'(g_wen_q[g0]), 64'(1));
        chk("t3_ren", 64'(g_ren_q[g0]), 64'(0));
        chk("t3_wdata", 64'(g_wd_q[g0]), 64'(32'h55AA));

        // Reset asserted mid-BUSY with req1 owning the bus
        do_reset();
        mem_hang = 1;
        set_req(1, 0, 1, 32'h40, 32'h0);
        wait_grant(10);
        chk("t4_owner_before", 64'(grant_o), 64'(2'b10));
        #2; rst_n = 1'b0; #1;
        chk("t4_async_grant", 64'(grant_o), 64'(0));
        chk("t4_async_strobe", 64'({mem_wen_o, mem_ren_o, mem_sel_o}), 64'(0));
        chk("t4_async_addr", 64'(mem_addr_o), 64'(0));
        chk("t4_async_rsp", 64'({req_ack_o, req_err_o}), 64'(0));
        set_req(0, 0, 1, 32'h44, 32'h0);
        mem_hang = 0; mem_lat = 0; mem_rdata_nx = 32'h4444; mem_err_nx = 1'b0;
        tick(1);
        rst_n = 1'b1;
        a0 = ack_q.size(); g0 = g_addr_q.size();
        wait_acks(a0 + 1, 20);
        drop_req(0); drop_req(1);
        tick(3);
        chk("t4_first_after_rst", 64'(g_own_q[g0]), 64'(2'b01));

        // Memory error, then a clean transaction clears it
        a0 = ack_q.size();
        do_txn(0, 0, 1, 32'h200, 32'h0, 1, 32'h1234, 1'b1);
        chk("t5_err", 64'(er_q[a0]), 64'(1));
        chk("t5_rdata", 64'(rd_q[a0]), 64'(32'h1234));
        do_txn(0, 0, 1, 32'h204, 32'h0, 0, 32'h5678, 1'b0);
        chk("t5_err_clear", 64'(er_q[a0+1]), 64'(0));
        chk("t5_rdata2", 64'(rd_q[a0+1]), 64'(32'h5678));

        // Requester drops its request while granted: still acked
        a0 = ack_q.size();
        mem_lat = 3; mem_rdata_nx = 32'hCAFE; mem_err_nx = 1'b0;
        set_req(1, 0, 1, 32'h300, 32'h0);
        wait_grant(10);
        drop_req(1);
        wait_acks(a0 + 1, 20);
        tick(2);
        chk("t6_ack_after_drop", 64'(ack_q[a0]), 64'(2'b10));

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never acks: watchdog completes with error, next requester served
        do_reset();
        a0 = ack_q.size(); g0 = g_addr_q.size();
        mem_hang = 1; mem_rdata_nx = 32'hFFFF; mem_err_nx = 1'b0;
        set_req(0, 0, 1, 32'h60, 32'h0);
        set_req(1, 0, 1, 32'h64, 32'h0);
        wait_acks(a0 + 1, 30);
        drop_req(0);
        mem_hang = 0; mem_lat = 0;
        wait_acks(a0 + 2, 30);
        drop_req(1);
        tick(3);
        chk("tmo_ack", 64'(ack_q[a0]), 64'(2'b01));
        chk("tmo_err", 64'(er_q[a0]), 64'(1));
        chk("tmo_rdata", 64'(rd_q[a0]), 64'(0));
        chk("tmo_cycles", 64'(ack_cyc_q[a0] - g_cyc_q[g0]), 64'(TO));
        chk("tmo_next_owner", 64'(g_own_q[g0+1]), 64'(2'b10));
`endif

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
